// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types for the ALU arbiter slice.
//   state_t  - arbiter FSM states
//   alu_op_t - 3-bit ALU control code with the named codes below
//   flags_t  - packed {n, z, v, c} ALU flag bundle
package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef logic [2:0] alu_op_t;

   localparam alu_op_t OP_PASS_B = 3'b000;
   localparam alu_op_t OP_ADD    = 3'b010;
   localparam alu_op_t OP_SUB    = 3'b011;
   localparam alu_op_t OP_AND    = 3'b100;
   localparam alu_op_t OP_OR     = 3'b101;
   localparam alu_op_t OP_XOR    = 3'b110;

   typedef struct packed {
      logic n;
      logic z;
      logic v;
      logic c;
   } flags_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the requester handshake and the shared-ALU bus.
//   Requester side: req_valid/req_ready, req_a/req_b/req_op per requester,
//                   rsp_valid/rsp_ready per requester, rsp_result, rsp_flags, flags, busy.
//   ALU side:       alu_a/alu_b/alu_op out to the ALU, alu_result and flag bits back.
//   slave  - used by the arbiter; master - used by the requesters/ALU environment.
interface alu_arbiter_if #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned NREQ  = 2
);
   import alu_arb_pkg::*;

   logic [NREQ-1:0]             req_valid;
   logic [NREQ-1:0]             req_ready;
   logic [NREQ-1:0][WIDTH-1:0]  req_a;
   logic [NREQ-1:0][WIDTH-1:0]  req_b;
   logic [NREQ-1:0][2:0]        req_op;
   logic [NREQ-1:0]             rsp_valid;
   logic [NREQ-1:0]             rsp_ready;
   logic [WIDTH-1:0]            rsp_result;
   flags_t                      rsp_flags;
   flags_t                      flags;
   logic                        busy;
   logic [WIDTH-1:0]            alu_a;
   logic [WIDTH-1:0]            alu_b;
   alu_op_t                     alu_op;
   logic [WIDTH-1:0]            alu_result;
   logic                        alu_neg;
   logic                        alu_zero;
   logic                        alu_ovf;
   logic                        alu_cout;

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      input  alu_result, alu_neg, alu_zero, alu_ovf, alu_cout,
      output req_ready, rsp_valid, rsp_result, rsp_flags, flags, busy,
      output alu_a, alu_b, alu_op
   );

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      output alu_result, alu_neg, alu_zero, alu_ovf, alu_cout,
      input  req_ready, rsp_valid, rsp_result, rsp_flags, flags, busy,
      input  alu_a, alu_b, alu_op
   );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin priority select over NREQ requests.
//   req - request vector
//   ptr - index with highest priority; search proceeds upward with wrap
//   gnt - one-hot grant (zero when no request)
//   idx - encoded index of the granted request
//   any - at least one request granted
module rr_arbiter #(
   parameter int unsigned NREQ = 2
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] idx,
   output logic                    any
);

   localparam int unsigned IW = $clog2(NREQ);

   int unsigned     pos;
   logic [IW-1:0]   pos_idx;

   always_comb begin
      gnt     = '0;
      idx     = '0;
      any     = 1'b0;
      pos     = 0;
      pos_idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         pos     = (32'(ptr) + i) % NREQ;
         pos_idx = IW'(pos);
         if (!any && req[pos_idx]) begin
            gnt[pos_idx] = 1'b1;
            idx          = pos_idx;
            any          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between NREQ requesters, granted round-robin.
//   clk, reset_n - clock (rising edge) and asynchronous active-low reset
//   bus          - alu_arbiter_if slave: request/response handshakes per requester,
//                  captured result/flags, persistent flags, busy, and the ALU bus.
// A granted operation holds its operands on the ALU for EXEC_CYCLES cycles, then the
// result and flags are captured and offered to the owner until it takes them.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int unsigned WIDTH       = 64,
   parameter int unsigned NREQ        = 2,
   parameter int unsigned EXEC_CYCLES = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   alu_arbiter_if.slave bus
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(EXEC_CYCLES - 1);

   state_t            state_q, state_d;
   logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   alu_op_t           op_q, op_d;
   logic [WIDTH-1:0]  res_q, res_d;
   flags_t            rflags_q, rflags_d;
   flags_t            flags_q, flags_d;

   logic [NREQ-1:0]   gnt;
   logic [IW-1:0]     gnt_idx;
   logic              gnt_any;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   rsp_valid;
   flags_t            alu_flags;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr (
      .req (bus.req_valid),
      .ptr (rr_ptr_q),
      .gnt (gnt),
      .idx (gnt_idx),
      .any (gnt_any)
   );

   always_comb begin
      alu_flags.n = bus.alu_neg;
      alu_flags.z = bus.alu_zero;
      alu_flags.v = bus.alu_ovf;
      alu_flags.c = bus.alu_cout;
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      res_d     = res_q;
      rflags_d  = rflags_q;
      flags_d   = flags_q;
      req_ready = '0;
      rsp_valid = '0;
      case (state_q)
         IDLE: begin
            // State is already IDLE while reset is held, so ready must be masked explicitly.
            if (reset_n) begin
               req_ready = gnt;
            end
            if (gnt_any) begin
               a_d     = bus.req_a[gnt_idx];
               b_d     = bus.req_b[gnt_idx];
               op_d    = bus.req_op[gnt_idx];
               owner_d = gnt_idx;
               cnt_d   = CNT_LOAD;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == '0) begin
               res_d    = bus.alu_result;
               rflags_d = alu_flags;
               flags_d  = alu_flags;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            rsp_valid[owner_q] = 1'b1;
            if (bus.rsp_ready[owner_q]) begin
               state_d  = IDLE;
               rr_ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= OP_PASS_B;
         res_q    <= '0;
         rflags_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         res_q    <= res_d;
         rflags_q <= rflags_d;
         flags_q  <= flags_d;
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.rsp_valid  = rsp_valid;
   assign bus.rsp_result = res_q;
   assign bus.rsp_flags  = rflags_q;
   assign bus.flags      = flags_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.alu_a      = a_q;
   assign bus.alu_b      = b_q;
   assign bus.alu_op     = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. The bench plays both the requesters
// and the gate-level ALU; the ALU model returns corrupted outputs until its operands have
// been stable long enough, so a capture taken too early yields a wrong result.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   localparam int unsigned WIDTH       = 64;
   localparam int unsigned NREQ        = 2;
   localparam int unsigned EXEC_CYCLES = 2;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   alu_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

   alu_arbiter #(
      .WIDTH       (WIDTH),
      .NREQ        (NREQ),
      .EXEC_CYCLES (EXEC_CYCLES)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int errors = 0;
   int checks = 0;
   int model_ptr = 0;

   logic [WIDTH-1:0] stim_a  [NREQ];
   logic [WIDTH-1:0] stim_b  [NREQ];
   logic [2:0]       stim_op [NREQ];

   // Reference ALU: returns {result, n, z, v, c}.
   function automatic logic [WIDTH+3:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [2:0] op);
      logic [WIDTH:0]   ext;
      logic [WIDTH-1:0] r;
      logic             v;
      logic             c;
      v = 1'b0;
      c = 1'b0;
      r = '0;
      case (op)
         3'b000: r = b;
         3'b010: begin
            ext = {1'b0, a} + {1'b0, b};
            r   = ext[WIDTH-1:0];
            c   = ext[WIDTH];
            v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         3'b011: begin
            ext = {1'b0, a} + {1'b0, ~b} + 1;
            r   = ext[WIDTH-1:0];
            c   = ext[WIDTH];
            v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         3'b100: r = a & b;
         3'b101: r = a | b;
         3'b110: r = a ^ b;
         default: r = '0;
      endcase
      return {r, r[WIDTH-1], (r == '0), v, c};
   endfunction

   // ALU settle model
   logic [2*WIDTH+2:0] seen;
   int                 stable = 0;
   logic [2*WIDTH+2:0] cur;
   assign cur = {bus.alu_a, bus.alu_b, bus.alu_op};

   always @(posedge clk) begin
      if (cur === seen) begin
         stable <= stable + 1;
      end else begin
         seen   <= cur;
         stable <= 0;
      end
   end

   always_comb begin
      logic [WIDTH+3:0] r;
      r = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);
      if (((cur === seen) ? stable + 2 : 1) < int'(EXEC_CYCLES)) r = ~r;
      {bus.alu_result, bus.alu_neg, bus.alu_zero, bus.alu_ovf, bus.alu_cout} = r;
   end

   function automatic int pick(input logic [NREQ-1:0] mask, input int ptr);
      int g;
      g = -1;
      for (int i = 0; i < int'(NREQ); i++) begin
         int j;
         j = (ptr + i) % int'(NREQ);
         if (g < 0 && mask[j]) g = j;
      end
      return g;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int g);
      logic [NREQ-1:0] v;
      v = '0;
      if (g >= 0) v[g] = 1'b1;
      return v;
   endfunction

   // One complete transaction from the stim_* tables; other valid requesters stay asserted
   // through the operation and must be offered the grant right after the release.
   task automatic do_op(input logic [NREQ-1:0] mask, input int stall, output int owner);
      int               g;
      int               nxt;
      logic [WIDTH+3:0] er;
      g     = pick(mask, model_ptr);
      owner = g;
      @(negedge clk);
      bus.req_valid = mask;
      for (int i = 0; i < int'(NREQ); i++) begin
         bus.req_a[i]  = stim_a[i];
         bus.req_b[i]  = stim_b[i];
         bus.req_op[i] = stim_op[i];
      end
      #1;
      checks++;
      if (bus.req_ready !== onehot(g)) begin
         errors++;
         $display("FAIL grant: req_ready=%b expected %b", bus.req_ready, onehot(g));
      end
      if (g < 0) begin
         bus.req_valid = '0;
         return;
      end
      er = alu_ref(stim_a[g], stim_b[g], stim_op[g]);
      for (int k = 1; k <= int'(EXEC_CYCLES); k++) begin
         @(negedge clk);
         #1;
         checks++;
         if (bus.alu_a !== stim_a[g] || bus.alu_b !== stim_b[g] || bus.alu_op !== stim_op[g] ||
             bus.rsp_valid !== '0 || bus.req_ready !== '0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL exec cycle %0d: alu_a=%h alu_b=%h op=%b rsp_valid=%b req_ready=%b busy=%b expected a=%h b=%h op=%b rsp_valid=0 req_ready=0 busy=1",
                     k, bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp_valid, bus.req_ready, bus.busy,
                     stim_a[g], stim_b[g], stim_op[g]);
         end
         if (k == 1) bus.req_valid[g] = 1'b0;
      end
      for (int s = 0; s <= stall; s++) begin
         @(negedge clk);
         #1;
         checks++;
         if (bus.rsp_valid !== onehot(g) || bus.rsp_result !== er[WIDTH+3:4] ||
             bus.rsp_flags !== er[3:0] || bus.flags !== er[3:0] || bus.req_ready !== '0 ||
             bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL resp cycle %0d: rsp_valid=%b result=%h rsp_flags=%b flags=%b req_ready=%b expected rsp_valid=%b result=%h flags=%b req_ready=0",
                     s, bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.flags, bus.req_ready,
                     onehot(g), er[WIDTH+3:4], er[3:0]);
         end
         // Non-owners' rsp_ready must be ignored while the owner stalls.
         bus.rsp_ready = (s == stall) ? onehot(g) : ~onehot(g);
      end
      @(negedge clk);
      bus.rsp_ready = '0;
      #1;
      model_ptr = (g + 1) % int'(NREQ);
      nxt       = pick(bus.req_valid, model_ptr);
      checks++;
      if (bus.busy !== 1'b0 || bus.rsp_valid !== '0 || bus.flags !== er[3:0] ||
          bus.req_ready !== onehot(nxt)) begin
         errors++;
         $display("FAIL release: busy=%b rsp_valid=%b flags=%b req_ready=%b expected busy=0 rsp_valid=0 flags=%b req_ready=%b",
                  bus.busy, bus.rsp_valid, bus.flags, bus.req_ready, er[3:0], onehot(nxt));
      end
      bus.req_valid = '0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         bus.req_valid = NREQ'($urandom);
         bus.rsp_ready = NREQ'($urandom);
         for (int i = 0; i < int'(NREQ); i++) begin
            bus.req_a[i]  = {$urandom, $urandom};
            bus.req_b[i]  = {$urandom, $urandom};
            bus.req_op[i] = 3'($urandom);
         end
         #1;
         checks++;
         if (bus.req_ready !== '0 || bus.rsp_valid !== '0 || bus.busy !== 1'b0 ||
             bus.rsp_result !== '0 || bus.rsp_flags !== 4'b0 || bus.flags !== 4'b0 ||
             bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_op !== 3'b000) begin
            errors++;
            $display("FAIL reset: req_ready=%b rsp_valid=%b busy=%b result=%h rsp_flags=%b flags=%b a=%h b=%h op=%b expected all zero",
                     bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_result, bus.rsp_flags,
                     bus.flags, bus.alu_a, bus.alu_b, bus.alu_op);
         end
      end
      @(negedge clk);
      bus.rsp_ready = '0;
      bus.req_valid = 2'b01;
      reset_n       = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 2'b01) begin
         errors++;
         $display("FAIL reset_release_r0: req_ready=%b expected 01", bus.req_ready);
      end
      bus.req_valid = 2'b11;
      #1;
      checks++;
      if (bus.req_ready !== 2'b01) begin
         errors++;
         $display("FAIL reset_release_both: req_ready=%b expected 01", bus.req_ready);
      end
      bus.req_valid = 2'b10;
      #1;
      checks++;
      if (bus.req_ready !== 2'b10) begin
         errors++;
         $display("FAIL reset_release_r1: req_ready=%b expected 10", bus.req_ready);
      end
      bus.req_valid = 2'b00;
      #1;
      checks++;
      if (bus.req_ready !== 2'b00 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_none: req_ready=%b busy=%b expected 00 0",
                  bus.req_ready, bus.busy);
      end
   endtask

   task automatic test_single_add();
      int o;
      stim_a[0] = 64'd5; stim_b[0] = 64'd7; stim_op[0] = OP_ADD;
      do_op(2'b01, 0, o);
      checks++;
      if (bus.rsp_result !== 64'd12 || bus.flags !== 4'b0000) begin
         errors++;
         $display("FAIL single_add: result=%0d flags=%b expected 12 0000",
                  bus.rsp_result, bus.flags);
      end
   endtask

   task automatic test_zero_carry();
      int o;
      stim_a[1] = 64'hFFFF_FFFF_FFFF_FFFF; stim_b[1] = 64'd1; stim_op[1] = OP_ADD;
      do_op(2'b10, 1, o);
      checks++;
      if (bus.rsp_result !== 64'd0 || bus.rsp_flags !== 4'b0101 || bus.flags !== 4'b0101) begin
         errors++;
         $display("FAIL zero_carry: result=%h rsp_flags=%b flags=%b expected 0 0101 0101",
                  bus.rsp_result, bus.rsp_flags, bus.flags);
      end
   endtask

   task automatic test_round_robin();
      int o;
      int expect_order [4] = '{0, 1, 0, 1};
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            stim_a[i]  = {$urandom, $urandom};
            stim_b[i]  = {$urandom, $urandom};
            stim_op[i] = (i == 0) ? OP_SUB : OP_XOR;
         end
         do_op(2'b11, 0, o);
         checks++;
         if (o !== expect_order[n]) begin
            errors++;
            $display("FAIL rr_order[%0d]: model owner=%0d expected %0d", n, o, expect_order[n]);
         end
      end
   endtask

   task automatic test_stall();
      int o;
      stim_a[0] = 64'h1234_5678_9ABC_DEF0; stim_b[0] = 64'h0F0F_0F0F_0F0F_0F0F; stim_op[0] = OP_AND;
      stim_a[1] = 64'd3;                   stim_b[1] = 64'd9;                   stim_op[1] = OP_SUB;
      do_op(2'b11, 10, o);
   endtask

   task automatic test_mid_reset();
      int o;
      @(negedge clk);
      bus.req_valid = 2'b10;
      bus.req_a[1]  = 64'd100;
      bus.req_b[1]  = 64'd200;
      bus.req_op[1] = OP_OR;
      #1;
      checks++;
      if (bus.req_ready !== onehot(pick(2'b10, model_ptr))) begin
         errors++;
         $display("FAIL midreset_grant: req_ready=%b expected 10", bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = '0;
      reset_n       = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.rsp_valid !== '0 || bus.alu_a !== '0 || bus.alu_op !== 3'b000 ||
          bus.flags !== 4'b0 || bus.rsp_result !== '0) begin
         errors++;
         $display("FAIL midreset_abort: busy=%b rsp_valid=%b alu_a=%h op=%b flags=%b result=%h expected zeros",
                  bus.busy, bus.rsp_valid, bus.alu_a, bus.alu_op, bus.flags, bus.rsp_result);
      end
      @(negedge clk);
      reset_n   = 1'b1;
      model_ptr = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (bus.rsp_valid !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_resp: rsp_valid=%b busy=%b expected 00 0",
                     bus.rsp_valid, bus.busy);
         end
      end
      stim_a[0] = 64'h8000_0000_0000_0000; stim_b[0] = 64'h8000_0000_0000_0000; stim_op[0] = OP_ADD;
      stim_a[1] = 64'd1;                   stim_b[1] = 64'd2;                   stim_op[1] = OP_ADD;
      do_op(2'b11, 0, o);
   endtask

   task automatic test_random();
      int o;
      logic [WIDTH-1:0] specials [4];
      logic [2:0]       codes    [7];
      specials = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};
      codes    = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
      for (int n = 0; n < 14; n++) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            stim_a[i]  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)]
                                                     : {$urandom, $urandom};
            stim_b[i]  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)]
                                                     : {$urandom, $urandom};
            stim_op[i] = codes[$urandom_range(0, 6)];
         end
         do_op(NREQ'($urandom_range(1, 3)), $urandom_range(0, 3), o);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n       = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_op    = '0;
      test_reset();
      test_single_add();
      test_zero_carry();
      test_round_robin();
      test_stall();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
